impulse_sequencer: RTL

//  Consumes the parameter set from the MCU SPI receiver (strobed by SPI_WR) and plays a pulse train

---
 rtl/impulse_pkg.sv | 25 ++
 rtl/impulse_sequencer_if.sv | 39 +++
 rtl/pulse_period_cnt.sv | 34 +++
 rtl/impulse_sequencer.sv | 82 ++++++++
 4 files changed

// File: rtl/impulse_pkg.sv
// impulse_pkg: widths, FSM state codes and the shadowed parameter set shared by the sequencer.
package impulse_pkg;

    localparam int TW = 64;
    localparam int FW = 48;
    localparam int CW = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ARMED = 2'd1;
    localparam state_t RUN   = 2'd2;

    typedef struct packed {
        logic [TW-1:0] time_start;
        logic [FW-1:0] freq;
        logic [FW-1:0] freq_step;
        logic [15:0]   n_impulse;
        logic [CW-1:0] ti;
        logic [CW-1:0] tp;
        logic [CW-1:0] tblank1;
        logic [CW-1:0] tblank2;
    } params_t;

endpackage

// File: rtl/impulse_sequencer_if.sv
// impulse_sequencer_if: SPI parameter set and system time in, gates and NCO strobes out.
interface impulse_sequencer_if;
    import impulse_pkg::*;

    logic          spi_wr;
    logic [TW-1:0] sys_time;
    logic [TW-1:0] time_start;
    logic [FW-1:0] freq;
    logic [FW-1:0] freq_step;
    logic [15:0]   n_impulse;
    logic [7:0]    type_imp;
    logic [CW-1:0] interval_ti;
    logic [CW-1:0] interval_tp;
    logic [CW-1:0] tblank1;
    logic [CW-1:0] tblank2;
    logic          pulse;
    logic          blank1;
    logic          blank2;
    logic          nco_load;
    logic [FW-1:0] freq_cur;
    logic [7:0]    type_out;
    logic          busy;
    logic          done;
    logic          late;
    logic          err;

    modport master (
        output spi_wr, sys_time, time_start, freq, freq_step, n_impulse, type_imp,
               interval_ti, interval_tp, tblank1, tblank2,
        input  pulse, blank1, blank2, nco_load, freq_cur, type_out, busy, done, late, err
    );

    modport slave (
        input  spi_wr, sys_time, time_start, freq, freq_step, n_impulse, type_imp,
               interval_ti, interval_tp, tblank1, tblank2,
        output pulse, blank1, blank2, nco_load, freq_cur, type_out, busy, done, late, err
    );

endinterface

// File: rtl/pulse_period_cnt.sv
// pulse_period_cnt: period counter c (0..tp-1) and pulse index k with wrap/last flags.
module pulse_period_cnt
    import impulse_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          start,
    input  logic          adv,
    input  logic [CW-1:0] tp,
    input  logic [15:0]   n_impulse,
    output logic [CW-1:0] c_nxt,
    output logic          wrap,
    output logic          last
);
    logic [CW-1:0] c;
    logic [15:0]   k;

    assign wrap  = c == tp - CW'(1);
    assign last  = k == n_impulse - 16'd1;
    // c_nxt lets the owner register gates aligned with the counter value they describe
    assign c_nxt = start ? '0 : adv ? (wrap ? '0 : c + CW'(1)) : c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            k <= '0;
        end else if (clk_en) begin
            c <= c_nxt;
            k <= start ? '0 : (adv && wrap) ? k + 16'd1 : k;
        end
    end

endmodule

// File: rtl/impulse_sequencer.sv
// impulse_sequencer: shadows the SPI parameter set, waits for the start time, then plays the
// pulse train with blanking gates and a per-pulse stepped NCO frequency word.
module impulse_sequencer
    import impulse_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    impulse_sequencer_if.slave bus
);
    params_t       p;
    state_t        state, state_nxt;
    logic [CW-1:0] c_nxt;
    logic          wrap, last, go, fire, start, adv, step, finish, run_nxt;

    assign go      = bus.sys_time >= p.time_start || p.time_start == '0;
    assign fire    = !bus.spi_wr && state == ARMED && go;
    assign start   = fire && p.n_impulse != '0;
    assign adv     = !bus.spi_wr && state == RUN;
    assign step    = adv && wrap && !last;
    assign finish  = adv && wrap && last;
    assign run_nxt = state_nxt == RUN;
    assign bus.busy = state != IDLE;

    // a new parameter set always wins, which is also how a running train is aborted
    always_comb
        state_nxt = bus.spi_wr ? (bus.interval_tp == '0 ? IDLE : ARMED) :
                    fire       ? (p.n_impulse == '0 ? IDLE : RUN) :
                    finish     ? IDLE : state;

    pulse_period_cnt u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .start     (start),
        .adv       (adv),
        .tp        (p.tp),
        .n_impulse (p.n_impulse),
        .c_nxt     (c_nxt),
        .wrap      (wrap),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            p            <= '0;
            bus.pulse    <= 1'b0;
            bus.blank1   <= 1'b0;
            bus.blank2   <= 1'b0;
            bus.nco_load <= 1'b0;
            bus.freq_cur <= '0;
            bus.type_out <= '0;
            bus.done     <= 1'b0;
            bus.late     <= 1'b0;
            bus.err      <= 1'b0;
        end else if (clk_en) begin
            state        <= state_nxt;
            bus.pulse    <= run_nxt && c_nxt < p.ti;
            bus.blank1   <= run_nxt && c_nxt < p.tblank1;
            bus.blank2   <= run_nxt && c_nxt < p.tblank2;
            bus.nco_load <= start || step;
            bus.done     <= (fire && p.n_impulse == '0) || finish;
            if (start)
                bus.freq_cur <= p.freq;
            else if (step)
                bus.freq_cur <= bus.freq_cur + p.freq_step;
            if (fire)
                bus.late <= bus.sys_time > p.time_start && p.time_start != '0;
            if (bus.spi_wr) begin
                p <= '{time_start: bus.time_start, freq: bus.freq, freq_step: bus.freq_step,
                       n_impulse: bus.n_impulse, ti: bus.interval_ti, tp: bus.interval_tp,
                       tblank1: bus.tblank1, tblank2: bus.tblank2};
                bus.late <= 1'b0;
                bus.err  <= bus.interval_tp == '0;
                if (bus.interval_tp != '0)
                    bus.type_out <= bus.type_imp;
            end
        end
    end

endmodule
